// File: rtl/mul_share_if.sv
// Requester and response channels between DSP/control clients
// and the shared 12x12 multiplier arbiter.
interface mul_share_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*12-1:0] req_x;
  logic [NREQ*12-1:0] req_y;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [23:0]        rsp_data;
  logic [IDW-1:0]     rsp_id;

  modport master (
    output req_valid,
    output req_x,
    output req_y,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_id
  );

  modport slave (
    input  req_valid,
    input  req_x,
    input  req_y,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_id
  );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one Wallace-tree 12x12 multiplier
// behind a two-stage operand/result pipeline.
module wallace12x12 (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [23:0] p
);
  logic [23:0] pp [12];
  logic [23:0] l1 [8];
  logic [23:0] l2 [6];
  logic [23:0] l3 [4];
  logic [23:0] l4 [3];
  logic [23:0] l5 [2];

  // Carry bits shifted past bit 23 are dropped: the true sum fits 24 bits.
  function automatic logic [47:0] csa(
    input logic [23:0] u,
    input logic [23:0] v,
    input logic [23:0] w
  );
    logic [23:0] s;
    logic [23:0] c;
    s = u ^ v ^ w;
    c = ((u & v) | (u & w) | (v & w)) << 1;
    return {c, s};
  endfunction

  always_comb begin
    for (int i = 0; i < 12; i++)
      pp[i] = b[i] ? ({12'b0, a} << i) : '0;
    for (int g = 0; g < 4; g++)
      {l1[2*g+1], l1[2*g]} =
        csa(pp[3*g], pp[3*g+1], pp[3*g+2]);
    for (int g = 0; g < 2; g++)
      {l2[2*g+1], l2[2*g]} =
        csa(l1[3*g], l1[3*g+1], l1[3*g+2]);
    l2[4] = l1[6];
    l2[5] = l1[7];
    for (int g = 0; g < 2; g++)
      {l3[2*g+1], l3[2*g]} =
        csa(l2[3*g], l2[3*g+1], l2[3*g+2]);
    {l4[1], l4[0]} = csa(l3[0], l3[1], l3[2]);
    l4[2] = l3[3];
    {l5[1], l5[0]} = csa(l4[0], l4[1], l4[2]);
    p = l5[0] + l5[1];
  end
endmodule

module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mul_share_if.slave      bus,
  output logic            busy,
  output logic [CNTW-1:0] done_cnt
);
  logic           op_vld;
  logic [11:0]    op_x;
  logic [11:0]    op_y;
  logic [IDW-1:0] op_id;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] grant_nxt;
  logic           any_req;
  logic           adv0;
  logic           adv1;
  logic           accept;
  logic [11:0]    sel_x;
  logic [11:0]    sel_y;
  logic [23:0]    prod;
  int             idx;

  assign adv1   = ~bus.rsp_valid | bus.rsp_ready;
  assign adv0   = ~op_vld | adv1;
  assign accept = any_req & adv0 & rst_n;

  // Walk downward so the nearest valid index after rr_ptr wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (bus.req_valid[idx]) begin
        grant   = IDW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign grant_nxt = IDW'((int'(grant) + 1) % NREQ);
  assign sel_x = bus.req_x[12*grant +: 12];
  assign sel_y = bus.req_y[12*grant +: 12];

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant] = 1'b1;
  end

  wallace12x12 u_mul (
    .a (op_x),
    .b (op_y),
    .p (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld <= 1'b0;
      op_x   <= '0;
      op_y   <= '0;
      op_id  <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      op_vld <= 1'b1;
      op_x   <= sel_x;
      op_y   <= sel_y;
      op_id  <= grant;
      rr_ptr <= grant_nxt;
    end else if (adv1) begin
      op_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= '0;
    end else if (adv1) begin
      bus.rsp_valid <= op_vld;
      if (op_vld) begin
        bus.rsp_data <= prod;
        bus.rsp_id   <= op_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      done_cnt <= '0;
    else if (bus.rsp_valid & bus.rsp_ready)
      done_cnt <= done_cnt + CNTW'(1);
  end

  assign busy = op_vld | bus.rsp_valid;
endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mul_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            busy;
  logic [CNTW-1:0] done_cnt;

  mul_share_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mul_share_arb #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [11:0] x; logic [11:0] y; } op_t;
  typedef struct { int id; logic [23:0] p; int e; } item_t;

  op_t         opq [NREQ][$];
  item_t       q [$];
  int          acc_log [$];
  int          acc_edge [$];
  int          rid_log [$];
  logic [23:0] rdat_log [$];
  int          seq [$];

  int vec = 0;
  int errs = 0;
  int edges = 0;
  int mptr = 0;
  int mcnt = 0;
  bit rnd_rdy = 1'b0;
  logic [NREQ-1:0] acc_mask = '0;

  bit              m_vis;
  bit              m_drain;
  bit              m_room;
  int              m_g;
  int              m_a;
  logic [NREQ-1:0] m_rdy;
  logic [11:0]     m_x;
  logic [11:0]     m_y;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit idle();
    bit r;
    r = q.size() == 0 && bus.req_valid == '0 && !bus.rsp_valid;
    for (int i = 0; i < NREQ; i++)
      if (opq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  always @(posedge clk) edges++;

  // Requester side: pop an operand once it was accepted, present the next.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_mask[i] && opq[i].size() > 0)
        void'(opq[i].pop_front());
      bus.req_valid[i] = opq[i].size() > 0;
      if (opq[i].size() > 0) begin
        bus.req_x[12*i +: 12] = opq[i][0].x;
        bus.req_y[12*i +: 12] = opq[i][0].y;
      end
    end
    acc_mask = '0;
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #2;
      bus.rsp_ready = $urandom_range(0, 3) != 0;
    end
  end

  // Reference model: in-flight items in order, at most two;
  // the oldest is visible one edge after it was accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mptr = 0;
      mcnt = 0;
      acc_mask = '0;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done_cnt", 32'(done_cnt), 0);
      chk("rst_req_ready", 32'(bus.req_ready), 0);
    end else begin
      m_vis = 1'b0;
      if (q.size() > 0) m_vis = edges >= q[0].e + 1;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_vis));
      if (m_vis) begin
        chk("rsp_data", 32'(bus.rsp_data), 32'(q[0].p));
        chk("rsp_id", 32'(bus.rsp_id), q[0].id);
      end
      chk("busy", 32'(busy), 32'(q.size() > 0));
      chk("done_cnt", 32'(done_cnt), mcnt % (1 << CNTW));
      m_drain = m_vis && bus.rsp_ready;
      m_room = q.size() < 2 || m_drain;
      m_g = -1;
      for (int k = 0; k < NREQ; k++)
        if (m_g < 0 && bus.req_valid[(mptr + k) % NREQ])
          m_g = (mptr + k) % NREQ;
      m_rdy = '0;
      if (m_room && m_g >= 0) m_rdy[m_g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(m_rdy));
      acc_mask = bus.req_ready;
      if (bus.req_ready != '0) begin
        m_a = 0;
        for (int i = 0; i < NREQ; i++)
          if (bus.req_ready[i]) m_a = i;
        acc_log.push_back(m_a);
        acc_edge.push_back(edges + 1);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rid_log.push_back(int'(bus.rsp_id));
        rdat_log.push_back(bus.rsp_data);
      end
      if (m_drain) begin
        void'(q.pop_front());
        mcnt++;
      end
      if (m_rdy != '0) begin
        m_x = bus.req_x[12*m_g +: 12];
        m_y = bus.req_y[12*m_g +: 12];
        q.push_back('{id: m_g, p: {12'b0, m_x} * {12'b0, m_y},
                      e: edges + 1});
        mptr = (m_g + 1) % NREQ;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) opq[i].delete();
    bus.req_valid = '0;
    #1;
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done_cnt", 32'(done_cnt), 0);
    chk("arst_req_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic clr_logs();
    acc_log.delete();
    acc_edge.delete();
    rid_log.delete();
    rdat_log.delete();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!idle() && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(idle()), 1);
  endtask

  task automatic rsp_at(input string name, input logic [23:0] d,
                        input int id);
    chk({name, "_valid"}, 32'(bus.rsp_valid), 1);
    chk({name, "_data"}, 32'(bus.rsp_data), 32'(d));
    chk({name, "_id"}, 32'(bus.rsp_id), id);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int prev;
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;

    // single request
    @(posedge clk); #2;
    opq[0].push_back('{12'd3, 12'd5});
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    chk("t1_not_yet", 32'(bus.rsp_valid), 0);
    chk("t1_busy", 32'(busy), 1);
    @(negedge clk);
    rsp_at("t1_rsp", 24'd15, 0);
    @(negedge clk);
    chk("t1_done", 32'(done_cnt), 1);
    chk("t1_idle", 32'(busy), 0);

    // full contention
    do_reset();
    clr_logs();
    @(posedge clk); #2;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NREQ; i++)
        opq[i].push_back('{12'(16*i + k + 1), 12'(i + 2*k + 3)});
    drain(60);
    chk("t2_nacc", acc_log.size(), 12);
    for (int j = 0; j < acc_log.size(); j++) begin
      chk("t2_grant", acc_log[j], j % 4);
      chk("t2_rate", acc_edge[j], acc_edge[0] + j);
    end
    chk("t2_nrsp", rid_log.size(), 12);
    for (int j = 0; j < rid_log.size(); j++)
      chk("t2_rsp_id", rid_log[j], j % 4);
    if (rdat_log.size() >= 2) begin
      chk("t2_p0", 32'(rdat_log[0]), 3);
      chk("t2_p1", 32'(rdat_log[1]), 68);
    end

    // backpressure
    do_reset();
    @(posedge clk); #2;
    bus.rsp_ready = 1'b0;
    opq[1].push_back('{12'd10, 12'd20});
    opq[1].push_back('{12'd50, 12'd60});
    opq[2].push_back('{12'd30, 12'd40});
    @(posedge clk);
    @(negedge clk);
    chk("t3_acc1", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    chk("t3_acc2", 32'(bus.req_ready), 32'h4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rsp_at("t3_hold", 24'd200, 1);
      chk("t3_stall", 32'(bus.req_ready), 0);
    end
    @(posedge clk); #2;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rsp_at("t3_r1", 24'd200, 1);
    chk("t3_next_acc", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    rsp_at("t3_r2", 24'd1200, 2);
    @(negedge clk);
    rsp_at("t3_r3", 24'd3000, 1);
    @(negedge clk);
    chk("t3_empty", 32'(bus.rsp_valid), 0);

    // corner operands, then random pairs
    do_reset();
    clr_logs();
    @(posedge clk); #2;
    opq[3].push_back('{12'd4095, 12'd4095});
    opq[3].push_back('{12'd0, 12'd4095});
    drain(20);
    chk("t4_n", rdat_log.size(), 2);
    if (rdat_log.size() >= 2) begin
      chk("t4_max", 32'(rdat_log[0]), 32'hFFE001);
      chk("t4_zero", 32'(rdat_log[1]), 0);
      chk("t4_id", rid_log[1], 3);
    end
    @(posedge clk); #2;
    for (int j = 0; j < 1000; j++)
      opq[$urandom_range(0, NREQ-1)].push_back(
        '{12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))});
    rnd_rdy = 1'b1;
    drain(8000);
    rnd_rdy = 1'b0;
    @(posedge clk); #2;
    bus.rsp_ready = 1'b1;

    // asynchronous reset with both stages full
    do_reset();
    @(posedge clk); #2;
    opq[2].push_back('{12'd7, 12'd9});
    opq[2].push_back('{12'd11, 12'd13});
    opq[2].push_back('{12'd100, 12'd200});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 10);
    chk("t5_first", 32'(bus.rsp_valid), 1);
    @(posedge clk); #2;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    rsp_at("t5_full", 24'd143, 2);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_cnt", 32'(done_cnt), 1);
    do_reset();
    @(posedge clk); #2;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_no_stale", 32'(bus.rsp_valid), 0);
      chk("t5_quiet", 32'(busy), 0);
    end
    @(posedge clk); #2;
    for (int i = 0; i < NREQ; i++)
      opq[i].push_back('{12'(i + 1), 12'd9});
    @(posedge clk);
    @(negedge clk);
    chk("t5_ptr0", 32'(bus.req_ready), 32'h1);
    drain(20);

    // counter wrap
    do_reset();
    @(posedge clk); #2;
    for (int j = 0; j < 17; j++)
      opq[j % NREQ].push_back('{12'(j + 1), 12'd2});
    prev = int'(done_cnt);
    seq.delete();
    for (int c = 0; c < 60 && seq.size() < 17; c++) begin
      @(negedge clk);
      if (int'(done_cnt) != prev) begin
        prev = int'(done_cnt);
        seq.push_back(prev);
      end
    end
    chk("t6_steps", seq.size(), 17);
    if (seq.size() == 17) begin
      chk("t6_15", seq[14], 15);
      chk("t6_wrap", seq[15], 0);
      chk("t6_1", seq[16], 1);
    end
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
